i2c_reg_target: RTL

I2C target (responder) with a 256 x 8 register file that answers the configuration writes issued by the HDMI-init I2C controller. It sits on the same SCL/SDA pair as the controller and stands in for the HDMI transmitter's main register map in loopback and simulation. It also gives the board a self-check path: the FPGA can configure itself and read the values back. It samples SCL/SDA on `clk_ref`, detects START/STOP, ACKs its device address, then accepts register writes or returns register reads.

---
 rtl/i2c_pkg.sv | 12 +
 rtl/i2c_reg_target_if.sv | 8 +
 rtl/i2c_line_sync.sv | 25 ++
 rtl/i2c_reg_target.sv | 132 +++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C register target.
// RDATA/RDATA_ACK exist only when I2C_TARGET_READ_EN is defined.
package i2c_pkg;
  localparam logic [6:0] I2C_ADDR_HDMI_TX = 7'h39;
  localparam int I2C_RW_BIT = 0;
  typedef enum logic [3:0] {
    IDLE = 4'd0, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK
`ifdef I2C_TARGET_READ_EN
    , RDATA, RDATA_ACK
`endif
  } i2c_state_e;
endpackage

// File: rtl/i2c_reg_target_if.sv
// i2c_reg_target_if: SCL/SDA pair as seen by the controller and by the target.
interface i2c_reg_target_if;
  logic i2c_scl;
  logic i2c_sda_in;
  logic i2c_sda_oe;
  modport master (output i2c_scl, i2c_sda_in, input i2c_sda_oe);
  modport slave (input i2c_scl, i2c_sda_in, output i2c_sda_oe);
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizer plus rise/fall pulses for one idle-high bus line.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_ref,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk_ref or negedge reset_n)
    if (!reset_n) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign q = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C responder with a 256x8 register file for HDMI-init loopback.
// Define I2C_TARGET_READ_EN to add the read path (RDATA/RDATA_ACK and SDA data drive).
module i2c_reg_target import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = I2C_ADDR_HDMI_TX,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_ref,
  input  logic                   reset_n,
  i2c_reg_target_if.slave        bus,
  output logic                   wr_strobe,
  output logic [7:0]             wr_addr,
  output logic [7:0]             wr_data,
  input  logic [7:0]             dbg_addr,
  output logic [7:0]             dbg_data,
  output logic                   busy,
  output logic [3:0]             state_out
);
  i2c_state_e state, state_d;
  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall, start, stop, hit, we, oe, oe_d, busy_d;
  logic [2:0] cnt, cnt_d;
  logic [7:0] ptr, ptr_d, byte_in;
  logic [7:0] reg_file [256];
`ifdef I2C_TARGET_READ_EN
  logic [7:0] shift, shift_d, rd_byte;
  assign rd_byte = reg_file[ptr];
  assign hit = byte_in[7:1] == DEV_ADDR;
`else
  logic [6:0] shift, shift_d;
  assign hit = byte_in[7:1] == DEV_ADDR && !byte_in[I2C_RW_BIT];
`endif
  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl (.clk_ref(clk_ref), .reset_n(reset_n), .d(bus.i2c_scl),
                                               .q(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda (.clk_ref(clk_ref), .reset_n(reset_n), .d(bus.i2c_sda_in),
                                               .q(sda), .rise(sda_rise), .fall(sda_fall));
  assign start = sda_fall & scl;
  assign stop = sda_rise & scl;
  assign byte_in = {shift[6:0], sda};
  assign bus.i2c_sda_oe = oe;
  assign dbg_data = reg_file[dbg_addr];
  assign state_out = state;
  always_ff @(posedge clk_ref or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    oe_d = oe;
    cnt_d = cnt;
    shift_d = shift;
    ptr_d = ptr;
    busy_d = busy;
    we = 1'b0;
    if (start) begin
      state_d = ADDR;
      cnt_d = '0;
      oe_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d = 1'b0;
      busy_d = 1'b0;
    end else case (state)
      ADDR, REG, WDATA: if (scl_rise) begin
        shift_d = byte_in[$high(shift):0];
        cnt_d = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_d = state == ADDR ? (hit ? ADDR_ACK : IDLE) : state == REG ? REG_ACK : WDATA_ACK;
          busy_d = state == ADDR ? hit : busy;
          ptr_d = state == REG ? byte_in : state == WDATA ? ptr + 8'd1 : ptr;
          we = state == WDATA;
        end
      end
      // first fall after the byte drives ACK, the next one releases it
      ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
        oe_d = ~oe;
        if (oe) state_d = state == ADDR_ACK ? REG : WDATA;
`ifdef I2C_TARGET_READ_EN
        if (oe && state == ADDR_ACK && shift[I2C_RW_BIT]) begin
          state_d = RDATA;
          oe_d = ~rd_byte[7];
          shift_d = {rd_byte[6:0], 1'b0};
        end
`endif
      end
`ifdef I2C_TARGET_READ_EN
      RDATA: begin
        if (scl_fall) begin
          oe_d = ~shift[7];
          shift_d = {shift[6:0], 1'b0};
        end
        if (scl_rise) begin
          cnt_d = cnt + 3'd1;
          if (cnt == 3'd7) state_d = RDATA_ACK;
        end
      end
      // shift is loaded unshifted here so the next RDATA fall presents bit 7
      RDATA_ACK: begin
        if (scl_fall) oe_d = 1'b0;
        if (scl_rise) begin
          state_d = sda ? IDLE : RDATA;
          ptr_d = sda ? ptr : ptr + 8'd1;
          shift_d = reg_file[ptr + 8'd1];
          cnt_d = '0;
        end
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk_ref or negedge reset_n)
    if (!reset_n) begin
      oe <= 1'b0;
      cnt <= '0;
      shift <= '0;
      ptr <= '0;
      busy <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < 256; i++) reg_file[i] <= '0;
    end else begin
      oe <= oe_d;
      cnt <= cnt_d;
      shift <= shift_d;
      ptr <= ptr_d;
      busy <= busy_d;
      wr_strobe <= we;
      if (we) begin
        wr_addr <= ptr;
        wr_data <= byte_in;
        reg_file[ptr] <= byte_in;
      end
    end
endmodule
